// File: rtl/matrix_rx.sv
// rtl/matrix_rx.sv - receiver for the 3-wire matrix LED link, decodes frames into a shadow register file
//
// Ports:
//   clk_9m      system clock, doubles as the serial bit clock
//   pll_rst     asynchronous reset, active-low
//   cs          frame enable, active-low; the first cycle it is sampled high latches the frame
//   din         serial data, MSB first, sampled on clk_9m rising edge while cs=0
//   rd_addr     row read select (0..7)
//   rd_row      row register[rd_addr], combinational
//   decode_mode register 0x9
//   intensity   register 0xA [3:0]
//   scan_limit  register 0xB [2:0]
//   shutdown_n  register 0xC [0], 0 = shutdown
//   disp_test   register 0xF [0]
//   frame_valid one-cycle pulse, frame committed
//   frame_err   one-cycle pulse, frame too short and discarded
//   frame_addr  address of the last committed frame
//   frame_data  data of the last committed frame

module matrix_rx #(
    parameter int FRAME_BITS = 16,
    parameter int CNT_W      = 8
) (
    input  logic       clk_9m,
    input  logic       pll_rst,
    input  logic       cs,
    input  logic       din,
    input  logic [2:0] rd_addr,
    output logic [7:0] rd_row,
    output logic [7:0] decode_mode,
    output logic [3:0] intensity,
    output logic [2:0] scan_limit,
    output logic       shutdown_n,
    output logic       disp_test,
    output logic       frame_valid,
    output logic       frame_err,
    output logic [3:0] frame_addr,
    output logic [7:0] frame_data
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [FRAME_BITS-1:0]   sr;
    logic [CNT_W-1:0]        cnt;
    logic [7:0]              rows [0:7];
    logic                    latch;
    logic                    commit;
    logic                    glitch;
    logic [3:0]              addr;
    logic [7:0]              data;
    logic                    unused_hi;

    // Only the low 12 bits of the frame carry address and data; the top nibble is don't-care.
    assign addr      = sr[11:8];
    assign data      = sr[7:0];
    assign unused_hi = ^sr[FRAME_BITS-1:12];

    // Read happens before any same-cycle write lands, so a colliding read sees the old row.
    assign rd_row = rows[rd_addr];

    // Daisy-chain semantics: any frame of at least FRAME_BITS bits commits its last FRAME_BITS bits.
    assign commit = latch && (cnt >= CNT_W'(FRAME_BITS));
    assign glitch = latch && !commit;

    always_ff @(posedge clk_9m or negedge pll_rst) begin
        if (!pll_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (!cs) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cs) begin
                    state_nxt = IDLE;
                    latch     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_9m or negedge pll_rst) begin
        if (!pll_rst) begin
            sr          <= '0;
            cnt         <= '0;
            decode_mode <= '0;
            intensity   <= '0;
            scan_limit  <= '0;
            shutdown_n  <= 1'b0;
            disp_test   <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_addr  <= '0;
            frame_data  <= '0;
            for (int i = 0; i < 8; i++) begin
                rows[i] <= '0;
            end
        end else begin
            frame_valid <= commit;
            frame_err   <= glitch;

            if (!cs) begin
                sr <= {sr[FRAME_BITS-2:0], din};
                // First bit out of IDLE restarts the count; in SHIFT the count saturates.
                if (state == IDLE) begin
                    cnt <= CNT_W'(1);
                end else if (cnt != '1) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (latch) begin
                cnt <= '0;
            end

            if (commit) begin
                frame_addr <= addr;
                frame_data <= data;
                case (addr)
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8: rows[3'(addr - 4'd1)] <= data;
                    4'h9: decode_mode <= data;
                    4'hA: intensity   <= data[3:0];
                    4'hB: scan_limit  <= data[2:0];
                    4'hC: shutdown_n  <= data[0];
                    4'hF: disp_test   <= data[0];
                    default: ;
                endcase
            end
        end
    end

endmodule
